// File: rtl/core_pkg.sv
// Shared definitions for the memory-port arbiter slice.
// Contents:
//   arb_state_t          - arbiter FSM encoding (ST_IDLE / ST_I_BUSY / ST_D_BUSY)
//   DEF_ADDR_W/DEF_DATA_W - default address / data widths
//   STREAK_W             - width of the MA-streak counter
package core_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int STREAK_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_I_BUSY = 2'd1,
    ST_D_BUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_streak_ctr.sv
// Counts consecutive MA grants made while IF is waiting. Saturates at MAX.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   inc       - an MA grant was made while IF was waiting
//   clr       - an IF grant was made, or IF is not requesting
//   at_limit  - counter has reached MAX; IF must win the next tie
module arb_streak_ctr
  import core_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(MAX);

  logic [STREAK_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port variable-latency memory between instruction fetch (IF)
// and memory access (MA). One transaction in flight at a time; results come
// back on registered rdata with a one-cycle done pulse.
//
// Handshake: a requester raises *_req and holds it (and its address/data) until
// its *_done pulse; the arbiter samples address/data only at the grant edge.
// Toward memory, mem_req and mem_* stay stable until the cycle mem_ready=1,
// which completes the access at that rising edge. mem_ready while no request
// is outstanding is ignored.
//
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   i_req/i_addr/i_flush         - IF request, address, cancel
//   i_done/i_rdata               - IF completion pulse and instruction word
//   d_req/d_we/d_be/d_addr/d_wdata - MA request (load/store)
//   d_done/d_rdata               - MA completion pulse and load data
//   stall_if, stall_ma           - combinational stalls to the hazard logic
//   mem_req/we/be/addr/wdata     - registered memory request
//   mem_ready, mem_rdata         - memory completion and read data
//   dbg_state                    - current FSM state
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_ma,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output arb_state_t        dbg_state
);

  arb_state_t state;
  logic       discard;
  logic       i_want;
  logic       grant_i;
  logic       grant_d;
  logic       at_limit;
  logic       idle;

  // A flushed fetch never competes; MA wins ties unless IF has been
  // starved for MAX_D_STREAK consecutive MA grants.
  assign idle    = (state == ST_IDLE);
  assign i_want  = i_req & ~i_flush;
  assign grant_d = idle & d_req & ~(i_want & at_limit);
  assign grant_i = idle & i_want & (~d_req | at_limit);

  assign stall_if  = i_req & ~i_done & ~i_flush;
  assign stall_ma  = d_req & ~d_done;
  assign dbg_state = state;

  arb_streak_ctr #(.MAX(MAX_D_STREAK)) u_streak (
    .clk      (clk),
    .rst      (rst),
    .inc      (grant_d & i_want),
    .clr      (grant_i | (idle & ~i_req)),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      discard   <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            state     <= ST_D_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grant_i) begin
            state     <= ST_I_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= 4'hF;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
          end
        end
        ST_I_BUSY: begin
          if (i_flush) discard <= 1'b1;
          if (mem_ready) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            discard <= 1'b0;
            // A flush arriving in the completion cycle also drops the result.
            if (!(discard || i_flush)) begin
              i_done  <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end
        end
        ST_D_BUSY: begin
          if (mem_ready) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            d_done  <= 1'b1;
            d_rdata <= mem_rdata;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: zero-wait fetch, simultaneous requests,
// wait states, flush in flight, starvation guard, reset mid-operation.
module tb_mem_port_arbiter;
  import core_pkg::*;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_flush;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        stall_if;
  logic        stall_ma;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  arb_state_t  dbg_state;

  logic        auto_ready;
  logic        man_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  // Zero-wait memory answers in the same cycle mem_req is seen.
  assign mem_ready = auto_ready ? mem_req : man_ready;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_flush   (i_flush),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .stall_if  (stall_if),
    .stall_ma  (stall_ma),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 0; i_addr = 0; i_flush = 0;
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    auto_ready = 0; man_ready = 0; mem_rdata = 0;
    step(); step();
    // A stray mem_ready during reset/idle must have no effect.
    man_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    man_ready = 1'b0;
    chk("rst_mem_req",  32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_i_done",   32'(i_done), 32'd0);
    chk("rst_d_done",   32'(d_done), 32'd0);
    chk("rst_i_rdata",  i_rdata, 32'd0);
    chk("rst_d_rdata",  d_rdata, 32'd0);
    chk("rst_state",    32'(dbg_state), 32'(ST_IDLE));

    // ---- Zero-wait fetch ----
    auto_ready = 1'b1;
    mem_rdata  = 32'h0050_0093;
    i_req = 1'b1; i_addr = 32'h100;
    #1 chk("zf_stall_c0", 32'(stall_if), 32'd1);
    step();
    chk("zf_mem_req_c1",  32'(mem_req), 32'd1);
    chk("zf_mem_addr_c1", mem_addr, 32'h100);
    chk("zf_mem_we_c1",   32'(mem_we), 32'd0);
    chk("zf_stall_c1",    32'(stall_if), 32'd1);
    step();
    chk("zf_i_done_c2",  32'(i_done), 32'd1);
    chk("zf_i_rdata_c2", i_rdata, 32'h0050_0093);
    chk("zf_stall_c2",   32'(stall_if), 32'd0);
    chk("zf_mem_req_c2", 32'(mem_req), 32'd0);
    i_req = 1'b0;
    step();
    chk("zf_i_done_c3",  32'(i_done), 32'd0);
    chk("zf_mem_req_c3", 32'(mem_req), 32'd0);

    // ---- Simultaneous requests: store wins, fetch follows ----
    mem_rdata = 32'h0000_0013;
    i_req = 1'b1; i_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    step();
    chk("sim_mem_we",    32'(mem_we), 32'd1);
    chk("sim_mem_addr",  mem_addr, 32'h2000);
    chk("sim_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sim_mem_be",    32'(mem_be), 32'hF);
    chk("sim_state_d",   32'(dbg_state), 32'(ST_D_BUSY));
    chk("sim_stall_if",  32'(stall_if), 32'd1);
    chk("sim_stall_ma",  32'(stall_ma), 32'd1);
    step();
    chk("sim_d_done",     32'(d_done), 32'd1);
    chk("sim_mem_req_c2", 32'(mem_req), 32'd0);
    chk("sim_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    d_req = 1'b0; d_we = 1'b0;
    step();
    chk("sim_i_grant_addr", mem_addr, 32'h104);
    chk("sim_i_grant_we",   32'(mem_we), 32'd0);
    chk("sim_i_state",      32'(dbg_state), 32'(ST_I_BUSY));
    step();
    chk("sim_i_done",  32'(i_done), 32'd1);
    chk("sim_i_rdata", i_rdata, 32'h0000_0013);
    i_req = 1'b0;
    step();

    // ---- Load with three wait states ----
    auto_ready = 1'b0; man_ready = 1'b0;
    mem_rdata = 32'h5555_5555;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("ws_mem_req",  32'(mem_req), 32'd1);
      chk("ws_mem_addr", mem_addr, 32'h2004);
      chk("ws_d_done",   32'(d_done), 32'd0);
      d_addr = 32'hFFFF_0000;
    end
    man_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    chk("ws_d_done_pulse", 32'(d_done), 32'd1);
    chk("ws_d_rdata",      d_rdata, 32'hCAFE_F00D);
    man_ready = 1'b0; d_req = 1'b0; mem_rdata = 32'h1111_1111;
    step();
    chk("ws_d_done_once", 32'(d_done), 32'd0);
    chk("ws_d_rdata_hold", d_rdata, 32'hCAFE_F00D);
    chk("ws_mem_req_off", 32'(mem_req), 32'd0);

    // ---- Flush while the fetch is in flight ----
    i_req = 1'b1; i_addr = 32'h200;
    step();
    chk("fl_state_ibusy", 32'(dbg_state), 32'(ST_I_BUSY));
    chk("fl_mem_addr",    mem_addr, 32'h200);
    i_flush = 1'b1;
    #1 chk("fl_stall_if", 32'(stall_if), 32'd0);
    step();
    i_flush = 1'b0; i_req = 1'b0;
    step();
    man_ready = 1'b1; mem_rdata = 32'h0000_0099;
    step();
    chk("fl_i_done",  32'(i_done), 32'd0);
    chk("fl_i_rdata", i_rdata, 32'h0000_0013);
    chk("fl_state",   32'(dbg_state), 32'(ST_IDLE));
    chk("fl_mem_req", 32'(mem_req), 32'd0);
    man_ready = 1'b0;
    step();
    chk("fl_i_done_late", 32'(i_done), 32'd0);

    // ---- Starvation guard: 4 MA grants then 1 IF grant, repeating ----
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) exp_q.push_back(32'h400);
      exp_q.push_back(32'h300);
    end
    auto_ready = 1'b1; mem_rdata = 32'h0;
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    for (int c = 0; c < 20; c++) begin
      step();
      if (mem_req) obs_q.push_back(mem_addr);
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("sv_grant_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int g = 0; g < exp_q.size(); g++) begin
      chk($sformatf("sv_grant_%0d", g), (g < obs_q.size()) ? obs_q[g] : 32'hFFFF_FFFF, exp_q[g]);
    end
    step(); step();

    // ---- Reset in the middle of a store ----
    auto_ready = 1'b0; man_ready = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h500; d_wdata = 32'h1;
    step();
    chk("rm_state_dbusy", 32'(dbg_state), 32'(ST_D_BUSY));
    rst = 1'b1;
    step();
    chk("rm_mem_req", 32'(mem_req), 32'd0);
    chk("rm_d_done",  32'(d_done), 32'd0);
    chk("rm_state",   32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0; d_req = 1'b0; d_we = 1'b0; man_ready = 1'b1;
    step();
    chk("rm_late_d_done",  32'(d_done), 32'd0);
    chk("rm_late_mem_req", 32'(mem_req), 32'd0);
    step();
    chk("rm_late_d_done2", 32'(d_done), 32'd0);
    man_ready = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
